// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative
// multiply/divide unit.
package muldiv_pkg;

  localparam int MAX_W2 = 128;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIN  = 2'b10
  } state_e;

  function automatic logic [MAX_W2-1:0] twos_neg(
    input logic [MAX_W2-1:0] x
  );
    return ~x + MAX_W2'(1);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration, either a
// shift-add multiply step or a restoring-divide step.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opb,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem;
  logic             ge;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
          + (acc[0] ? {1'b0, opb} : '0);
    // remainder shifted left with the next dividend bit
    trial = acc[2*WIDTH-1:WIDTH-1];
    ge    = trial >= {1'b0, opb};
    rem   = ge ? WIDTH'(trial - {1'b0, opb})
               : trial[WIDTH-1:0];
    if (is_div) begin
      acc_nxt = {rem, acc[WIDTH-2:0], ge};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO
// registers and MTHI/MTLO writes, one bit per cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             a_neg_q, a_neg_d;
  logic             dz_q, dz_d;

  op_e              op_i;
  logic             sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo, rem;
  logic [W2-1:0]    prod;

  function automatic logic [WIDTH-1:0] neg_w(
    input logic [WIDTH-1:0] x
  );
    return WIDTH'(twos_neg(MAX_W2'(x)));
  endfunction

  function automatic logic [W2-1:0] neg_2w(
    input logic [W2-1:0] x
  );
    return W2'(twos_neg(MAX_W2'(x)));
  endfunction

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .opb     (opb_q),
    .acc_nxt (acc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_FIN);
  end

  always_comb begin
    op_i  = op_e'(op);
    sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
    sa    = sgn & a[WIDTH-1];
    sb    = sgn & b[WIDTH-1];
    mag_a = sa ? neg_w(a) : a;
    mag_b = sb ? neg_w(b) : b;
    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[W2-1:WIDTH];
    prod  = neg_q ? neg_2w(acc_q) : acc_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    dz_d     = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_hi) hi_d = wd;
        if (wr_lo) lo_d = wd;
        if (start) begin
          is_div_d = (op_i == OP_DIV) || (op_i == OP_DIVU);
          neg_d    = sa ^ sb;
          a_neg_d  = sa;
          dz_d     = is_div_d && (b == '0);
          opb_d    = mag_b;
          acc_d    = {{WIDTH{1'b0}}, mag_a};
          cnt_d    = CW'(WIDTH - 1);
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
      end
      S_FIN: begin
        if (is_div_q) begin
          // remainder of a zero divisor is |a|, so this restores a
          hi_d = a_neg_q ? neg_w(rem) : rem;
          if (dz_q) begin
            lo_d = '1;
          end else begin
            lo_d = neg_q ? neg_w(quo) : quo;
          end
        end else begin
          hi_d = prod[W2-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      dz_q     <= dz_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with a result scoreboard
// checked by an independent done monitor.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wd;
  logic         wr_hi, wr_lo;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [W-1:0] qh[$];
  logic [W-1:0] ql[$];
  int           qc[$];
  logic [W-1:0] eh, el;
  int           ec;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string        nm,
    input logic [W-1:0] act,
    input logic [W-1:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] h,
                      input logic [W-1:0] l);
    qh.push_back(h);
    ql.push_back(l);
    qc.push_back(cyc);
  endtask

  task automatic issue(
    input logic [1:0]   o,
    input logic [W-1:0] xa,
    input logic [W-1:0] xb,
    input bit           p,
    input logic [W-1:0] h,
    input logic [W-1:0] l
  );
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = xa;
    b = xb;
    @(posedge clk);
    #1;
    if (p) push(h, l);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL wait_idle: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (qh.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done: got done=1 expected none at cycle %0d",
                   cyc);
        end else begin
          eh = qh.pop_front();
          el = ql.pop_front();
          ec = qc.pop_front();
          chk("done_latency", W'(cyc - ec), W'(W));
          @(posedge clk);
          #1;
          chk("result_hi", hi, eh);
          chk("result_lo", lo, el);
        end
      end
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    wd = '0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    reset = 1'b0;

    @(negedge clk);
    wr_hi = 1'b1;
    wd = 32'h0000_AAAA;
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi", hi, 32'h0000_AAAA);
    chk("mthi_lo_held", lo, 0);
    wr_lo = 1'b1;
    wd = 32'h0000_5555;
    @(negedge clk);
    wr_lo = 1'b0;
    chk("mtlo", lo, 32'h0000_5555);
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    wd = 32'h0000_0077;
    @(negedge clk);
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    chk("mt_both_hi", hi, 32'h77);
    chk("mt_both_lo", lo, 32'h77);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
          32'hFFFF_FFFE, 32'h0000_0001);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (done) break;
    end
    chk("busy_cycles", W'(n), W'(W + 1));

    issue(2'b00, 32'hFFFF_FFF9, 32'h0000_0006, 1'b1,
          32'hFFFF_FFFF, 32'hFFFF_FFD6);
    chk("b2b_accept", W'(busy), 1);
    wait_idle();

    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1,
          32'h4000_0000, 32'h0000_0000);
    wait_idle();

    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1,
          32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_idle();

    issue(2'b11, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    repeat (3) @(negedge clk);
    wr_lo = 1'b1;
    wd = 32'h0000_5555;
    start = 1'b1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd5;
    @(negedge clk);
    wr_lo = 1'b0;
    start = 1'b0;
    chk("calc_lo_held", lo, 32'hFFFF_FFFD);
    chk("calc_hi_held", hi, 32'hFFFF_FFFF);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_second_op", W'(busy), 0);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
          32'h0000_0000, 32'h8000_0000);
    wait_idle();

    @(negedge clk);
    wr_hi = 1'b1;
    wd = 32'h0000_BEEF;
    start = 1'b1;
    op = 2'b01;
    a = 32'd3;
    b = 32'd5;
    @(posedge clk);
    #1;
    push(32'd0, 32'd15);
    start = 1'b0;
    wr_hi = 1'b0;
    chk("start_mt_hi", hi, 32'h0000_BEEF);
    wait_idle();

    issue(2'b11, 32'h0000_1234, 32'h0, 1'b1,
          32'h0000_1234, 32'hFFFF_FFFF);
    wait_idle();
    issue(2'b10, 32'hFFFF_FFF8, 32'h0, 1'b1,
          32'hFFFF_FFF8, 32'hFFFF_FFFF);
    wait_idle();

    issue(2'b10, 32'h0001_2345, 32'd3, 1'b0, '0, '0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", W'(busy), 0);
    chk("midrst_done", W'(done), 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(negedge clk);
    reset = 1'b0;

    issue(2'b01, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15);
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_empty", W'(qh.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, sitting beside the single-cycle ALU in the MIPS datapath to execute MULT/MULTU/DIV/DIVU and MTHI/MTLO/MFHI/MFLO. Generalised in operand width; computes one bit per cycle under a small FSM with start/busy/done handshaking. While an operation is pending, the controller stalls any MFHI/MFLO using `busy`.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥ 4.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request a new operation; sampled only in IDLE.
- op  in  2  operation, captured with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand / dividend, captured with start.
- b  in  WIDTH  rt operand / divisor, captured with start.
- wr_hi  in  1  MTHI write strobe.
- wr_lo  in  1  MTLO write strobe.
- wd  in  WIDTH  MTHI/MTLO write data.
- busy  out  1  high in CALC and FIN; reset 0.
- done  out  1  one-cycle pulse in FIN; reset 0.
- hi  out  WIDTH  HI register: product upper half or remainder; reset 0.
- lo  out  WIDTH  LO register: product lower half or quotient; reset 0.

## Operation
- FSM states: IDLE, CALC, FIN.
  - IDLE → CALC when start=1. Latch op, |a|, |b|, sign flags, and cnt=WIDTH-1.
  - CALC: one iteration per cycle. cnt decrements; when cnt=0, go to FIN.
  - FIN: apply sign fixup, write hi/lo, assert done, return to IDLE.
- Signed ops (MULT, DIV):
  - Operate on magnitudes; |x| of the most-negative value is 2^(WIDTH-1), held in an unsigned WIDTH-bit register.
  - Product is negated if the sign of a differs from the sign of b.
  - Quotient is negated if the sign of a differs from the sign of b; remainder takes the sign of a.
- Multiply: radix-2 shift-add on a 2·WIDTH-bit accumulator. {hi,lo} = full 2·WIDTH-bit product.
- Divide: restoring, one quotient bit per cycle. lo = quotient (truncated toward zero), hi = remainder.
- Divide by zero (b=0), any divide op:
  - Same latency; no error flag.
  - lo = all ones, hi = a (the original a, unmodified).
- Signed overflow, DIV with a = 0x80..0 and b = all ones: lo = 0x80..0, hi = 0. This is the natural wrap from the algorithm.
- MTHI/MTLO:
  - In IDLE, wr_hi loads hi <= wd and wr_lo loads lo <= wd on the next edge.
  - Both strobes may be asserted in the same cycle.
  - Ignored while busy=1.
- Precedence: start and wr_* in the same IDLE cycle → the writes take effect, and the operation starts. FIN then overwrites hi/lo.
- start while busy=1 is ignored; it is not queued.
- hi/lo change only in FIN or on an accepted MT write. They hold their previous values throughout CALC.

## Timing
- start sampled high at edge 0 → busy=1 from edge 0 through edge WIDTH (CALC occupies WIDTH cycles).
- FIN occupies the cycle after edge WIDTH: done=1 and busy=1 in that cycle. hi/lo are updated at edge WIDTH+1, after which the FSM is back in IDLE.
- Total latency: WIDTH+1 cycles from start to new hi/lo. Back-to-back throughput: one operation per WIDTH+2 cycles; start is accepted the cycle after done.
- Outputs are registered, with no combinational path from inputs to busy/done/hi/lo.
- reset asserted mid-operation: immediately IDLE, busy=0, done=0, hi=lo=0. The in-flight operation is discarded.

## Structure
- Package muldiv_pkg:
  - typedef enum logic [1:0] for op: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - typedef enum for FSM state: S_IDLE, S_CALC, S_FIN.
  - Function for two's-complement negate.
- Counter width: $clog2(WIDTH).
- One sub-module: muldiv_step. Combinational single-iteration datapath: one add/shift step for multiply, or one trial-subtract step for divide, selected by the latched op class. The FSM, counter, sign fixup and HI/LO registers stay in muldiv_unit.
- Extend aludec/maindec separately; this block exposes only the ports above.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for 33 cycles.
- MULT a=-7 (0xFFFFFFF9), b=6 → hi=0xFFFFFFFF, lo=0xFFFFFFD6; MULT a=0x80000000, b=0x80000000 → hi=0x40000000, lo=0.
- DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=100, b=7 → lo=14, hi=2; DIV a=0x80000000, b=-1 → lo=0x80000000, hi=0.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234, same latency.
- wr_hi wd=0xAAAA in IDLE → hi=0xAAAA next cycle. wr_lo during CALC → ignored. start during CALC → ignored, with no second done. start the cycle after done → accepted.
- reset pulsed 10 cycles into a DIV → busy=0, done=0, hi=lo=0. A subsequent MULTU 3×5 → lo=15, hi=0.
